// File: rtl/writeback_ecc_cycle.sv
// Writeback stage with ECC error handling.
// Selects the register-file result, aligns the MEM-stage ECC flags into WB, blocks writeback of
// uncorrectable load data, counts corrected errors (saturating), captures the first
// uncorrectable error and raises a trap request held until acknowledged.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   RegWriteW, ResultSrcW    MEM/WB control: write request, 1 = load data / 0 = ALU result
//   RD_W, PCPlus4W           destination register, PC+4 of the WB instruction
//   ALU_ResultW, ReadDataW   ALU result / effective address, ECC-corrected load data
//   ResultSrcM, s_errM,      MEM-stage load qualifier and ECC flags (corrected / uncorrectable)
//   d_errM
//   err_clr, trap_ack        clear error status, trap accepted by control unit
//   ResultW, RegWriteEnW,    register-file write data, gated enable, destination
//   RD_outW
//   trap_req                 uncorrectable-error trap request
//   err_addr, err_pc         address and PC of the first captured uncorrectable error
//   sec_count                saturating corrected-error count
//   ded_sticky, ded_multi    error captured since clear / further error while pending or captured

module writeback_ecc_cycle #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWriteW,
  input  logic             ResultSrcW,
  input  logic [4:0]       RD_W,
  input  logic [31:0]      PCPlus4W,
  input  logic [31:0]      ALU_ResultW,
  input  logic [31:0]      ReadDataW,
  input  logic             ResultSrcM,
  input  logic             s_errM,
  input  logic             d_errM,
  input  logic             err_clr,
  input  logic             trap_ack,
  output logic [31:0]      ResultW,
  output logic             RegWriteEnW,
  output logic [4:0]       RD_outW,
  output logic             trap_req,
  output logic [31:0]      err_addr,
  output logic [31:0]      err_pc,
  output logic [CNT_W-1:0] sec_count,
  output logic             ded_sticky,
  output logic             ded_multi
);

  typedef enum logic [0:0] {StNormal, StTrapPend} state_e;

  state_e r_state, w_state_next;

  logic             r_sec_w, r_ded_w;
  logic [CNT_W-1:0] r_sec_count;
  logic             r_ded_sticky, r_ded_multi;
  logic [31:0]      r_err_addr, r_err_pc;

  logic w_capture;
  logic w_multi_evt;
  logic w_sec_inc;

  // ECC flags only matter for loads; register them so they line up with the WB instruction.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sec_w <= 1'b0;
      r_ded_w <= 1'b0;
    end else begin
      r_sec_w <= s_errM & ResultSrcM;
      r_ded_w <= d_errM & ResultSrcM;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= StNormal;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StNormal:   if (r_ded_w)  w_state_next = StTrapPend;
      StTrapPend: if (trap_ack) w_state_next = StNormal;
      default:                  w_state_next = StNormal;
    endcase
  end

  // FSM outputs
  always_comb begin
    trap_req    = (r_state == StTrapPend);
    RegWriteEnW = RegWriteW & ~r_ded_w & (r_state == StNormal) & (RD_W != 5'd0);
  end

  assign ResultW = ResultSrcW ? ReadDataW : ALU_ResultW;
  assign RD_outW = RD_W;

  // Only the first DED seen in NORMAL is captured; any later one just marks ded_multi.
  assign w_capture   = r_ded_w & (r_state == StNormal) & ~r_ded_sticky;
  assign w_multi_evt = r_ded_w & ((r_state == StTrapPend) | r_ded_sticky);
  assign w_sec_inc   = r_sec_w & ~r_ded_w;

  // Error status; a same-cycle event wins over err_clr.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sec_count  <= '0;
      r_ded_sticky <= 1'b0;
      r_ded_multi  <= 1'b0;
      r_err_addr   <= 32'd0;
      r_err_pc     <= 32'd0;
    end else begin
      if (err_clr) begin
        r_sec_count <= w_sec_inc ? CNT_W'(1) : '0;
      end else if (w_sec_inc && (r_sec_count != {CNT_W{1'b1}})) begin
        r_sec_count <= r_sec_count + CNT_W'(1);
      end

      if (w_capture) begin
        r_ded_sticky <= 1'b1;
        r_err_addr   <= ALU_ResultW;
        r_err_pc     <= PCPlus4W - 32'd4;
      end else if (err_clr) begin
        r_ded_sticky <= 1'b0;
      end

      if (w_multi_evt) begin
        r_ded_multi <= 1'b1;
      end else if (err_clr) begin
        r_ded_multi <= 1'b0;
      end
    end
  end

  assign sec_count  = r_sec_count;
  assign ded_sticky = r_ded_sticky;
  assign ded_multi  = r_ded_multi;
  assign err_addr   = r_err_addr;
  assign err_pc     = r_err_pc;

endmodule

// File: tb/tb_writeback_ecc_cycle.sv
module tb_writeback_ecc_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteW, ResultSrcW, ResultSrcM, s_errM, d_errM, err_clr, trap_ack;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;

  logic [31:0] ResultW, err_addr, err_pc;
  logic        RegWriteEnW, trap_req, ded_sticky, ded_multi;
  logic [4:0]  RD_outW;
  logic [7:0]  sec_count;

  // Narrow-counter instance for saturation checks; only sec_count is inspected.
  logic [31:0] c2_ResultW, c2_err_addr, c2_err_pc;
  logic        c2_RegWriteEnW, c2_trap_req, c2_ded_sticky, c2_ded_multi;
  logic [4:0]  c2_RD_outW;
  logic [1:0]  c2_sec_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  writeback_ecc_cycle u_dut (
    .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
    .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW),
    .ResultSrcM(ResultSrcM), .s_errM(s_errM), .d_errM(d_errM), .err_clr(err_clr),
    .trap_ack(trap_ack), .ResultW(ResultW), .RegWriteEnW(RegWriteEnW), .RD_outW(RD_outW),
    .trap_req(trap_req), .err_addr(err_addr), .err_pc(err_pc), .sec_count(sec_count),
    .ded_sticky(ded_sticky), .ded_multi(ded_multi)
  );

  writeback_ecc_cycle #(.CNT_W(2)) u_dut_c2 (
    .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
    .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW),
    .ResultSrcM(ResultSrcM), .s_errM(s_errM), .d_errM(d_errM), .err_clr(err_clr),
    .trap_ack(trap_ack), .ResultW(c2_ResultW), .RegWriteEnW(c2_RegWriteEnW),
    .RD_outW(c2_RD_outW), .trap_req(c2_trap_req), .err_addr(c2_err_addr),
    .err_pc(c2_err_pc), .sec_count(c2_sec_count), .ded_sticky(c2_ded_sticky),
    .ded_multi(c2_ded_multi)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_flags(input logic src, input logic s, input logic d);
    ResultSrcM = src;
    s_errM     = s;
    d_errM     = d;
  endtask

  initial begin
    rst = 1'b0; RegWriteW = 1'b0; ResultSrcW = 1'b0; RD_W = 5'd0; PCPlus4W = 32'd0;
    ALU_ResultW = 32'd0; ReadDataW = 32'd0; err_clr = 1'b0; trap_ack = 1'b0;
    mem_flags(1'b0, 1'b0, 1'b0);
    tick(); tick();
    rst = 1'b1;
    check_eq("rst_trap_req", 32'(trap_req), 32'd0);
    check_eq("rst_sec_count", 32'(sec_count), 32'd0);
    check_eq("rst_sticky", 32'(ded_sticky), 32'd0);
    check_eq("rst_err_addr", err_addr, 32'd0);

    // ALU op
    ResultSrcW = 1'b0; ALU_ResultW = 32'h1234; RegWriteW = 1'b1; RD_W = 5'd5; #1;
    check_eq("alu_result", ResultW, 32'h1234);
    check_eq("alu_wen", 32'(RegWriteEnW), 32'd1);
    check_eq("alu_rd", 32'(RD_outW), 32'd5);

    // Corrected-error load
    mem_flags(1'b1, 1'b1, 1'b0);
    tick();
    mem_flags(1'b0, 1'b0, 1'b0);
    ResultSrcW = 1'b1; ReadDataW = 32'hCAFEF00D; #1;
    check_eq("sec_result", ResultW, 32'hCAFEF00D);
    check_eq("sec_wen", 32'(RegWriteEnW), 32'd1);
    check_eq("sec_cnt_before", 32'(sec_count), 32'd0);
    tick();
    check_eq("sec_cnt_after", 32'(sec_count), 32'd1);

    // s_errM on a non-load is ignored
    mem_flags(1'b0, 1'b1, 1'b0);
    tick();
    mem_flags(1'b0, 1'b0, 1'b0);
    tick();
    check_eq("nonload_no_count", 32'(sec_count), 32'd1);

    // DED load at 0x40 / PC+4 0x104
    mem_flags(1'b1, 1'b0, 1'b1);
    tick();
    mem_flags(1'b0, 1'b0, 1'b0);
    ALU_ResultW = 32'h40; PCPlus4W = 32'h104; RegWriteW = 1'b1; RD_W = 5'd7; #1;
    check_eq("ded_wen_blocked", 32'(RegWriteEnW), 32'd0);
    check_eq("ded_trap_not_yet", 32'(trap_req), 32'd0);
    tick();
    check_eq("ded_trap_req", 32'(trap_req), 32'd1);
    check_eq("ded_err_addr", err_addr, 32'h40);
    check_eq("ded_err_pc", err_pc, 32'h100);
    check_eq("ded_sticky", 32'(ded_sticky), 32'd1);
    check_eq("ded_multi_clear", 32'(ded_multi), 32'd0);
    check_eq("pend_wen_blocked", 32'(RegWriteEnW), 32'd0);

    // Second DED while pending
    mem_flags(1'b1, 1'b0, 1'b1);
    tick();
    mem_flags(1'b0, 1'b0, 1'b0);
    ALU_ResultW = 32'h80; PCPlus4W = 32'h200;
    tick();
    check_eq("multi_set", 32'(ded_multi), 32'd1);
    check_eq("multi_addr_kept", err_addr, 32'h40);
    check_eq("multi_pc_kept", err_pc, 32'h100);
    check_eq("trap_held", 32'(trap_req), 32'd1);
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
    check_eq("ack_trap_low", 32'(trap_req), 32'd0);
    check_eq("ack_wen_back", 32'(RegWriteEnW), 32'd1);

    // err_clr keeps captured address/pc
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_eq("clr_sec", 32'(sec_count), 32'd0);
    check_eq("clr_sticky", 32'(ded_sticky), 32'd0);
    check_eq("clr_multi", 32'(ded_multi), 32'd0);
    check_eq("clr_addr_kept", err_addr, 32'h40);

    // trap_ack in NORMAL is ignored
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
    check_eq("ack_normal_ignored", 32'(trap_req), 32'd0);

    // Capture beats err_clr; PC+4 of 0 wraps
    mem_flags(1'b1, 1'b0, 1'b1);
    tick();
    mem_flags(1'b0, 1'b0, 1'b0);
    ALU_ResultW = 32'h99; PCPlus4W = 32'd0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_eq("capclr_sticky", 32'(ded_sticky), 32'd1);
    check_eq("capclr_addr", err_addr, 32'h99);
    check_eq("capclr_pc_wrap", err_pc, 32'hFFFFFFFC);
    check_eq("capclr_trap", 32'(trap_req), 32'd1);
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;

    // Five corrected loads: narrow counter saturates at 3
    mem_flags(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    mem_flags(1'b0, 1'b0, 1'b0);
    tick();
    check_eq("sat_c2", 32'(c2_sec_count), 32'd3);
    check_eq("sat_c8", 32'(sec_count), 32'd5);

    // err_clr with secW in the same cycle
    mem_flags(1'b1, 1'b1, 1'b0);
    tick();
    mem_flags(1'b0, 1'b0, 1'b0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_eq("clr_sec_same_c2", 32'(c2_sec_count), 32'd1);
    check_eq("clr_sec_same_c8", 32'(sec_count), 32'd1);

    // Reset while trap pending
    mem_flags(1'b1, 1'b1, 1'b1);
    tick();
    mem_flags(1'b0, 1'b0, 1'b0);
    tick();
    check_eq("pre_rst_trap", 32'(trap_req), 32'd1);
    check_eq("sec_with_ded_not_counted", 32'(sec_count), 32'd1);
    rst = 1'b0;
    tick();
    check_eq("rst_pend_trap", 32'(trap_req), 32'd0);
    check_eq("rst_pend_sec", 32'(sec_count), 32'd0);
    check_eq("rst_pend_sticky", 32'(ded_sticky), 32'd0);
    check_eq("rst_pend_multi", 32'(ded_multi), 32'd0);
    check_eq("rst_pend_addr", err_addr, 32'd0);
    check_eq("rst_pend_pc", err_pc, 32'd0);
    RegWriteW = 1'b1; RD_W = 5'd3; #1;
    check_eq("rst_wen_follows", 32'(RegWriteEnW), 32'd1);
    rst = 1'b1;
    RD_W = 5'd0; #1;
    check_eq("rd0_no_write", 32'(RegWriteEnW), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
